// File: rtl/hkspi_pkg.sv
// Shared constants and state encoding for the housekeeping SPI master sequencer.
package hkspi_pkg;
  localparam logic [7:0] HKSPI_CMD_WRITE = 8'h80;
  localparam logic [7:0] HKSPI_CMD_READ  = 8'h40;

  // Housekeeping register addresses
  localparam logic [7:0] PRODUCT_ID = 8'h03;
  localparam logic [7:0] EXT_RESET  = 8'h0b;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_CMD, ST_ADDR, ST_DATA, ST_HOLD, ST_GAP
  } hkspi_state_e;
endpackage

// File: rtl/hkspi_bit_engine.sv
// Mode-0 bit engine: divides the clock into SCK low/high phases and shifts one byte
// MSB first, sampling SDO on the cycle SCK rises.
module hkspi_bit_engine #(
  parameter int CLK_DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       sdo,
  output logic       active,
  output logic       byte_done,
  output logic       rx_last,
  output logic [7:0] rx_byte,
  output logic       sck,
  output logic       sdi
);
  logic [7:0] r_cnt;
  logic [2:0] r_bit;
  logic [6:0] r_shift;
  logic [6:0] r_rx;
  logic       r_active, r_sck, r_sdi;
  logic       w_tick;

  assign w_tick    = r_active && (r_cnt == 8'(CLK_DIV - 1));
  // byte_done is combinational so a following byte can start without a gap in the cadence
  assign byte_done = w_tick && r_sck && (r_bit == 3'd7);
  assign rx_last   = w_tick && !r_sck && (r_bit == 3'd7);
  assign rx_byte   = {r_rx, sdo};
  assign active    = r_active;
  assign sck       = r_sck;
  assign sdi       = r_sdi;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_rx     <= '0;
      r_sck    <= 1'b0;
      r_sdi    <= 1'b0;
    end else if (start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_sck    <= 1'b0;
      r_sdi    <= tx_byte[7];
      r_shift  <= tx_byte[6:0];
    end else if (r_active) begin
      if (w_tick) begin
        r_cnt <= '0;
        if (!r_sck) begin
          r_sck <= 1'b1;
          r_rx  <= rx_byte[6:0];
        end else begin
          r_sck <= 1'b0;
          if (r_bit == 3'd7) begin
            r_active <= 1'b0;
          end else begin
            r_bit   <= r_bit + 3'd1;
            r_sdi   <= r_shift[6];
            r_shift <= {r_shift[5:0], 1'b0};
          end
        end
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end
endmodule

// File: rtl/hkspi_master_seq.sv
// Housekeeping SPI master: turns one request into a CSB-framed command/address/data
// stream, with write-data flow control and read-data return.
module hkspi_master_seq
  import hkspi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_GAP   = 4,
  parameter int LEN_W    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [7:0]       req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             spi_csb,
  output logic             spi_sck,
  output logic             spi_sdi,
  input  logic             spi_sdo
);
  hkspi_state_e     r_state, w_next;
  logic [7:0]       r_cnt;
  logic             r_write;
  logic [7:0]       r_addr;
  logic [LEN_W-1:0] r_len;
  logic             r_csb, r_ready, r_busy, r_done, r_rd_valid;
  logic [7:0]       r_rd_data;
  logic             r_sdo_meta, r_sdo_sync;

  logic       w_start, w_wr_ready, w_slot, w_in_frame;
  logic [7:0] w_tx, w_rx_byte;
  logic       w_eng_active, w_byte_done, w_rx_last;

  hkspi_bit_engine #(.CLK_DIV(CLK_DIV)) u_eng (
    .clock(clock), .reset(reset), .start(w_start), .tx_byte(w_tx), .sdo(r_sdo_sync),
    .active(w_eng_active), .byte_done(w_byte_done), .rx_last(w_rx_last),
    .rx_byte(w_rx_byte), .sck(spi_sck), .sdi(spi_sdi)
  );

  // Data-byte slot: end of address, end of a data byte, or a write stall waiting on wr_valid
  assign w_slot = ((r_state == ST_ADDR) && w_byte_done) ||
                  ((r_state == ST_DATA) && (w_byte_done || !w_eng_active));

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_tx       = 8'h00;
    w_wr_ready = 1'b0;
    case (r_state)
      ST_IDLE:  if (req_valid && r_ready) w_next = ST_SETUP;
      ST_SETUP: if (r_cnt == 8'(CS_SETUP - 1)) begin
        w_start = 1'b1;
        w_tx    = r_write ? HKSPI_CMD_WRITE : HKSPI_CMD_READ;
        w_next  = ST_CMD;
      end
      ST_CMD: if (w_byte_done) begin
        w_start = 1'b1;
        w_tx    = r_addr;
        w_next  = ST_ADDR;
      end
      ST_ADDR, ST_DATA: if (w_slot) begin
        if (r_len == '0) begin
          w_next = ST_HOLD;
        end else begin
          w_next = ST_DATA;
          if (!r_write) begin
            w_start = 1'b1;
          end else if (wr_valid) begin
            w_start    = 1'b1;
            w_tx       = wr_data;
            w_wr_ready = 1'b1;
          end
        end
      end
      ST_HOLD: if (r_cnt == 8'(CLK_DIV - 1)) w_next = ST_GAP;
      ST_GAP:  if (r_cnt == 8'(CS_GAP - 1))  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_in_frame = (w_next == ST_SETUP) || (w_next == ST_CMD) || (w_next == ST_ADDR) ||
                      (w_next == ST_DATA)  || (w_next == ST_HOLD);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_csb      <= 1'b1;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_sdo_meta <= 1'b0;
      r_sdo_sync <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
      r_csb      <= !w_in_frame;
      r_ready    <= (w_next == ST_IDLE);
      r_busy     <= (w_next != ST_IDLE);
      r_done     <= (r_state == ST_HOLD) && (w_next == ST_GAP);
      r_sdo_meta <= spi_sdo;
      r_sdo_sync <= r_sdo_meta;
      if (r_state == ST_IDLE && w_next == ST_SETUP) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_len   <= req_len;
      end else if (w_start && (r_state == ST_ADDR || r_state == ST_DATA)) begin
        r_len <= r_len - 1'b1;
      end
      r_rd_valid <= (r_state == ST_DATA) && !r_write && w_rx_last;
      if ((r_state == ST_DATA) && !r_write && w_rx_last) r_rd_data <= w_rx_byte;
    end
  end

  assign req_ready = r_ready;
  assign wr_ready  = w_wr_ready;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign spi_csb   = r_csb;
endmodule

// File: tb/tb_hkspi_master_seq.sv
// Directed bench for hkspi_master_seq: a housekeeping slave model on the main instance,
// plus a CLK_DIV=1 instance for the fast command+address-only frame.
module tb_hkspi_master_seq;
  import hkspi_pkg::*;

  localparam logic [7:0] HK_MEM [0:31] = '{
    8'h00, 8'h04, 8'h56, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'hff, 8'hef, 8'hff,
    8'h03, 8'h12, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       req_valid = 0, req_write = 0, wr_valid = 0, sdo;
  logic [7:0] req_addr = 0, wr_data = 0;
  logic [4:0] req_len = 0;
  logic       req_ready, wr_ready, rd_valid, busy, done, csb, sck, sdi;
  logic [7:0] rd_data;

  logic       req_valid1 = 0, req_write1 = 0, wr_valid1 = 0, sdo1 = 0;
  logic [7:0] req_addr1 = 0, wr_data1 = 0;
  logic [4:0] req_len1 = 0;
  logic       req_ready1, wr_ready1, rd_valid1, busy1, done1, csb1, sck1, sdi1;
  logic [7:0] rd_data1;

  hkspi_master_seq #(.CLK_DIV(4), .CS_SETUP(2), .CS_GAP(4), .LEN_W(5)) u_dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .spi_csb(csb), .spi_sck(sck), .spi_sdi(sdi), .spi_sdo(sdo));

  hkspi_master_seq #(.CLK_DIV(1), .CS_SETUP(2), .CS_GAP(4), .LEN_W(5)) u_dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write1), .req_addr(req_addr1), .req_len(req_len1),
    .wr_data(wr_data1), .wr_valid(wr_valid1), .wr_ready(wr_ready1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1), .done(done1),
    .spi_csb(csb1), .spi_sck(sck1), .spi_sdi(sdi1), .spi_sdo(sdo1));

  // Slave model: captures bytes on SCK rise, drives read data on SCK fall with auto-increment
  logic [7:0] s_sh = 0, s_cmd = 0, s_addr = 0;
  int         s_cnt = 0;
  logic [7:0] s_log [$];

  always @(posedge sck or posedge csb) begin
    if (csb) s_cnt <= 0;
    else begin
      s_sh  <= {s_sh[6:0], sdi};
      s_cnt <= s_cnt + 1;
      if (s_cnt % 8 == 7) s_log.push_back({s_sh[6:0], sdi});
      if (s_cnt == 7)  s_cmd  <= {s_sh[6:0], sdi};
      if (s_cnt == 15) s_addr <= {s_sh[6:0], sdi};
    end
  end

  always @(negedge sck or posedge csb) begin
    if (csb) sdo <= 1'b0;
    else if (s_cmd == HKSPI_CMD_READ && s_cnt >= 16)
      sdo <= HK_MEM[(int'(s_addr) + (s_cnt - 16) / 8) % 32][7 - (s_cnt % 8)];
  end

  // Observation counters, sampled on the falling clock edge
  int rises = 0, rdv = 0, dones = 0, wrr = 0, coinc = 0, csb_rises = 0, busy_rdy = 0;
  int hi_run = 0, last_gap = 0, cyc = 0;
  logic prev_sck = 0, prev_csb = 1;
  logic [7:0] rdq [$];
  int rises1 = 0, dones1 = 0, rdv1 = 0, wrr1 = 0, first1 = 0, last1 = 0;
  logic prev_sck1 = 0;
  logic [15:0] sh1 = 0;

  always @(negedge clock) begin
    cyc      <= cyc + 1;
    prev_sck <= sck;
    prev_csb <= csb;
    if (sck && !prev_sck) rises <= rises + 1;
    if (rd_valid) begin rdv <= rdv + 1; rdq.push_back(rd_data); end
    if (done) dones <= dones + 1;
    if (wr_ready) wrr <= wr_ready ? wrr + 1 : wrr;
    if (rd_valid && wr_ready) coinc <= coinc + 1;
    if (req_ready && busy) busy_rdy <= busy_rdy + 1;
    if (csb && !prev_csb) csb_rises <= csb_rises + 1;
    if (csb) hi_run <= hi_run + 1;
    else begin
      if (prev_csb) last_gap <= hi_run;
      hi_run <= 0;
    end
    prev_sck1 <= sck1;
    if (sck1 && !prev_sck1) begin
      if (rises1 == 0) first1 <= cyc;
      last1  <= cyc;
      rises1 <= rises1 + 1;
      sh1    <= {sh1[14:0], sdi1};
    end
    if (done1) dones1 <= dones1 + 1;
    if (rd_valid1) rdv1 <= rdv1 + 1;
    if (wr_ready1) wrr1 <= wrr1 + 1;
  end

  int n_cmp = 0, n_err = 0;
  int b_r, b_rd, b_d, b_l, b_c, b_q, b_w, s_r, stall_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic w, input logic [7:0] a, input logic [4:0] l);
    int n = 0;
    @(negedge clock);
    req_write = w; req_addr = a; req_len = l; req_valid = 1'b1;
    while (!req_ready && n < 3000) begin @(negedge clock); n++; end
    chk("req_accept_timeout", 32'(n < 3000), 1);
    @(posedge clock); #1 req_valid = 1'b0;
  endtask

  task automatic wait_dones(input int tgt);
    int n = 0;
    while (dones < tgt && n < 5000) begin @(negedge clock); n++; end
    chk("done_timeout", 32'(n < 5000), 1);
    repeat (10) @(negedge clock);
  endtask

  task automatic wait_wrr(input int tgt);
    int n = 0;
    while (wrr < tgt && n < 3000) begin @(negedge clock); n++; end
    chk("wr_ready_timeout", 32'(n < 3000), 1);
  endtask

  task automatic wait_rises(input int tgt);
    int n = 0;
    while (rises < tgt && n < 3000) begin @(negedge clock); n++; end
    chk("sck_rise_timeout", 32'(n < 3000), 1);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_csb", 32'(csb), 1);
    chk("rst_sck", 32'(sck), 0);
    chk("rst_sdi", 32'(sdi), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle_req_ready", 32'(req_ready), 1);

    // 1: single-byte read of PRODUCT_ID
    b_r = rises; b_rd = rdv; b_d = dones; b_l = s_log.size(); b_c = csb_rises; b_q = rdq.size();
    send_req(1'b0, PRODUCT_ID, 5'd1);
    wait_dones(b_d + 1);
    chk("t1_cmd", 32'(s_log[b_l]), 32'h40);
    chk("t1_addr", 32'(s_log[b_l + 1]), 32'h03);
    chk("t1_rises", 32'(rises - b_r), 24);
    chk("t1_rd_cnt", 32'(rdv - b_rd), 1);
    chk("t1_rd_data", 32'(rdq[b_q]), 32'h11);
    chk("t1_done_cnt", 32'(dones - b_d), 1);
    chk("t1_csb_rises", 32'(csb_rises - b_c), 1);

    // 2: 19-byte stream read from address 0
    b_r = rises; b_rd = rdv; b_d = dones; b_q = rdq.size();
    send_req(1'b0, 8'h00, 5'd19);
    wait_dones(b_d + 1);
    chk("t2_rises", 32'(rises - b_r), 168);
    chk("t2_rd_cnt", 32'(rdv - b_rd), 19);
    for (int i = 0; i < 19; i++) chk($sformatf("t2_rd_%0d", i), 32'(rdq[b_q + i]), 32'(HK_MEM[i]));

    // 3: back-to-back EXT_RESET writes, second request pending while busy
    b_d = dones; b_l = s_log.size(); b_w = wrr;
    wr_data = 8'h01; wr_valid = 1'b1;
    send_req(1'b1, EXT_RESET, 5'd1);
    wait_wrr(b_w + 1);
    wr_data = 8'h00;
    send_req(1'b1, EXT_RESET, 5'd1);
    wait_wrr(b_w + 2);
    wr_valid = 1'b0;
    wait_dones(b_d + 2);
    chk("t3_b0", 32'(s_log[b_l]), 32'h80);
    chk("t3_b1", 32'(s_log[b_l + 1]), 32'h0b);
    chk("t3_b2", 32'(s_log[b_l + 2]), 32'h01);
    chk("t3_b3", 32'(s_log[b_l + 3]), 32'h80);
    chk("t3_b4", 32'(s_log[b_l + 4]), 32'h0b);
    chk("t3_b5", 32'(s_log[b_l + 5]), 32'h00);
    chk("t3_csb_gap_ge5", 32'(last_gap >= 5), 1);
    chk("t3_ready_while_busy", 32'(busy_rdy), 0);

    // 4: two-byte write with a 40-cycle write-data stall before byte 2
    b_r = rises; b_d = dones; b_l = s_log.size(); b_w = wrr;
    wr_data = 8'hA5; wr_valid = 1'b1;
    send_req(1'b1, 8'h20, 5'd2);
    wait_wrr(b_w + 1);
    wr_valid = 1'b0;
    wait_rises(b_r + 24);
    repeat (10) @(negedge clock);
    s_r = rises; stall_bad = 0;
    repeat (40) begin
      @(negedge clock);
      if (sck !== 1'b0 || csb !== 1'b0) stall_bad++;
    end
    chk("t4_stall_levels", 32'(stall_bad), 0);
    chk("t4_stall_rises", 32'(rises - s_r), 0);
    wr_data = 8'h3C; wr_valid = 1'b1;
    wait_wrr(b_w + 2);
    wr_valid = 1'b0;
    wait_dones(b_d + 1);
    chk("t4_b2", 32'(s_log[b_l + 2]), 32'hA5);
    chk("t4_b3", 32'(s_log[b_l + 3]), 32'h3C);
    chk("t4_rises", 32'(rises - b_r), 32);
    chk("t4_wr_ready_cnt", 32'(wrr - b_w), 2);
    chk("rd_wr_coincide", 32'(coinc), 0);

    // 5: reset during the address byte of a read
    b_r = rises; b_rd = rdv; b_d = dones; b_q = rdq.size();
    send_req(1'b0, PRODUCT_ID, 5'd2);
    wait_rises(b_r + 12);
    #2 reset = 1'b1;
    #1;
    chk("t5_csb_async", 32'(csb), 1);
    chk("t5_sck_async", 32'(sck), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("t5_no_done", 32'(dones - b_d), 0);
    chk("t5_no_rd", 32'(rdv - b_rd), 0);
    send_req(1'b0, PRODUCT_ID, 5'd1);
    wait_dones(b_d + 1);
    chk("t5_rd_cnt", 32'(rdv - b_rd), 1);
    chk("t5_rd_data", 32'(rdq[b_q]), 32'h11);

    // 6: command+address only at CLK_DIV=1
    begin
      int n = 0;
      @(negedge clock);
      req_write1 = 1'b0; req_addr1 = EXT_RESET; req_len1 = 5'd0; req_valid1 = 1'b1;
      while (!req_ready1 && n < 100) begin @(negedge clock); n++; end
      chk("t6_accept_timeout", 32'(n < 100), 1);
      @(posedge clock); #1 req_valid1 = 1'b0;
      n = 0;
      while (dones1 < 1 && n < 500) begin @(negedge clock); n++; end
      chk("t6_done_timeout", 32'(n < 500), 1);
      repeat (5) @(negedge clock);
    end
    chk("t6_rises", 32'(rises1), 16);
    chk("t6_period", 32'(last1 - first1), 30);
    chk("t6_sdi_bits", 32'(sh1), 32'h400b);
    chk("t6_done_cnt", 32'(dones1), 1);
    chk("t6_no_rd", 32'(rdv1), 0);
    chk("t6_no_wr", 32'(wrr1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
